// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the instruction-memory boot loader.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam int HDR_BYTES = 2;
  typedef enum logic [2:0] {HDR_HI, HDR_LO, LOAD, RUN, ERR} boot_state_e;
endpackage

// File: rtl/boot_ram.sv
// boot_ram: instruction RAM with one synchronous write port and one combinational read port.
module boot_ram
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a big-endian byte-stream program into instruction RAM,
// then releases the processor from reset and serves fetches at pc.
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_synch,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [31:0]       pc,
  output logic [31:0]       instruction,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam logic [16:0] DEPTH = 17'(2**ADDR_W);
  boot_state_e state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0] idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic [ADDR_W:0] words_q, words_d;
  logic fire, we, rd_ok;
  logic [15:0] hdr;
  logic [31:0] pc_w;
  logic [WORD_W-1:0] rdata;
  always_ff @(posedge clock) begin
    if (reset_synch) begin
      state_q <= HDR_HI;
      count_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      words_q <= words_d;
    end
  end
  always_comb begin
    fire    = byte_valid && byte_ready;
    hdr     = {count_q[15:8], byte_in};
    we      = fire && state_q == LOAD && idx_q == 2'd3;
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    word_d  = word_q;
    words_d = words_q;
    if (fire) begin
      case (state_q)
        HDR_HI: begin
          count_d[15:8] = byte_in;
          state_d = HDR_LO;
        end
        HDR_LO: begin
          count_d = hdr;
          state_d = hdr == 16'd0 ? RUN : {1'b0, hdr} > DEPTH ? ERR : LOAD;
        end
        LOAD: begin
          idx_d  = idx_q + 2'd1;
          word_d = {word_q[15:0], byte_in};
          if (idx_q == 2'd3) begin
            words_d = words_q + 1'b1;
            if (32'(words_d) == 32'(count_q)) state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    byte_ready   = !reset_synch && (state_q == HDR_HI || state_q == HDR_LO || state_q == LOAD);
    cpu_reset_n  = state_q == RUN;
    load_done    = state_q == RUN;
    load_error   = state_q == ERR;
    words_loaded = words_q;
    pc_w         = pc >> 2;
    rd_ok        = pc_w[31:ADDR_W] == '0 && {1'b0, pc_w[ADDR_W-1:0]} < words_q;
    instruction  = rd_ok ? rdata : NOP_INSTR;
  end
  boot_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk  (clock),
    .we   (we),
    .waddr(words_q[ADDR_W-1:0]),
    .wdata({word_q, byte_in}),
    .raddr(pc_w[ADDR_W-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed streams with a scoreboard queue checked by a negedge monitor.
module tb_imem_boot_loader;
  logic clock = 1'b0, reset_synch = 1'b1, byte_valid = 1'b0, byte_ready;
  logic [7:0] byte_in = 8'h00;
  logic [31:0] pc = 32'h0, instruction;
  logic cpu_reset_n, load_done, load_error;
  logic [8:0] words_loaded;
  imem_boot_loader #(.ADDR_W(8)) dut (
    .clock(clock), .reset_synch(reset_synch), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .pc(pc), .instruction(instruction), .cpu_reset_n(cpu_reset_n),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );
  always #5 clock = ~clock;
  typedef struct {string name; int kind; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  logic chk = 1'b0;
  int tests = 0, fails = 0;
  always @(negedge clock) begin
    exp_t e;
    logic [31:0] act;
    if (chk) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: monitor got a check request with no expected value queued");
      end else begin
        e = sb.pop_front();
        act = e.kind == 0 ? instruction : e.kind == 1 ? 32'(words_loaded)
            : {28'b0, cpu_reset_n, load_done, load_error, byte_ready};
        if (act !== e.exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end
  task automatic expect_(input int kind, input string name, input logic [31:0] exp);
    sb.push_back('{name, kind, exp});
    chk = 1'b1;
    @(negedge clock);
    #1 chk = 1'b0;
    @(posedge clock);
    #1;
  endtask
  task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp);
    pc = a;
    expect_(0, name, exp);
  endtask
  task automatic wl(input string name, input int n);
    expect_(1, name, 32'(n));
  endtask
  // status bits: {cpu_reset_n, load_done, load_error, byte_ready}
  task automatic st(input string name, input logic [3:0] s);
    expect_(2, name, 32'(s));
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clock);
    #1 byte_valid = 1'b0;
    if (gap) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic do_reset(input string name);
    reset_synch = 1'b1;
    @(posedge clock);
    #1;
    st({name, "_in_reset"}, 4'b0000);
    wl({name, "_words0"}, 0);
    reset_synch = 1'b0;
    st({name, "_after"}, 4'b0001);
  endtask
  logic [7:0] s1 [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
  logic [31:0] wv;
  initial begin
    do_reset("rst0");
    for (int i = 0; i < 9; i++) send(s1[i], 1'b0);
    st("t1_pre_done", 4'b0001);
    wl("t1_words1", 1);
    send(s1[9], 1'b0);
    st("t1_done", 4'b1100);
    wl("t1_words2", 2);
    rd(32'h0, "t1_pc0", 32'h2008_0005);
    rd(32'h4, "t1_pc4", 32'h0000_000C);
    rd(32'h5, "t1_pc5_low_bits", 32'h0000_000C);
    rd(32'h8, "t1_pc8", 32'h0);
    rd(32'h1000_0000, "t1_pc_high", 32'h0);
    send(8'hFF, 1'b0);
    st("t1_run_ignores", 4'b1100);
    wl("t1_words_still2", 2);
    do_reset("rst1");
    for (int i = 0; i < 9; i++) send(s1[i], 1'b1);
    st("t2_pre_done", 4'b0001);
    send(s1[9], 1'b1);
    st("t2_done", 4'b1100);
    wl("t2_words2", 2);
    rd(32'h0, "t2_pc0", 32'h2008_0005);
    rd(32'h4, "t2_pc4", 32'h0000_000C);
    do_reset("rst2");
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    st("t3_zero_run", 4'b1100);
    rd(32'h0, "t3_pc0", 32'h0);
    rd(32'h4, "t3_pc4", 32'h0);
    wl("t3_words0", 0);
    do_reset("rst3");
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    st("t4_err", 4'b0010);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    st("t4_err_stays", 4'b0010);
    wl("t4_words0", 0);
    do_reset("rst4");
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    for (int w = 0; w < 256; w++) begin
      wv = {8'(w), 8'hA5, 8'h5A, ~8'(w)};
      for (int b = 0; b < 4; b++) send(wv[31-8*b -: 8], 1'b0);
    end
    st("t5_done", 4'b1100);
    wl("t5_words256", 256);
    rd(32'h3FC, "t5_last", 32'hFFA5_5A00);
    rd(32'h0, "t5_first", 32'h00A5_5AFF);
    rd(32'h400, "t5_beyond", 32'h0);
    do_reset("rst5");
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    wl("t6_words1", 1);
    rd(32'h0, "t6_partial_pc0", 32'h1122_3344);
    do_reset("rst6");
    rd(32'h0, "t6_masked_pc0", 32'h0);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    wl("t6_reload_words0", 0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    wl("t6_reload_words0b", 0);
    send(8'hEF, 1'b0);
    st("t6_done", 4'b1100);
    wl("t6_words1b", 1);
    rd(32'h0, "t6_pc0", 32'hDEAD_BEEF);
    rd(32'h4, "t6_pc4", 32'h0);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
